// File: rtl/param_serializer_pkg.sv
// Shared types and elaboration helpers for the parametrised word serializer.
package param_serializer_pkg;

   // Shifter FSM: IDLE waits for a queued word, SHIFT streams its symbols.
   typedef enum logic {
      StIdle  = 1'b0,
      StShift = 1'b1
   } state_e;

   // Ceiling log2 usable in constant expressions; clog2(1) = 0.
   function automatic int unsigned clog2(input int unsigned value);
      int unsigned r;
      r = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(value)) r = i + 1;
      end
      return r;
   endfunction

   // Number of LANES-wide symbols in one DATA_W-bit word.
   function automatic int unsigned calc_syms(input int unsigned data_w,
                                             input int unsigned lanes);
      return data_w / lanes;
   endfunction

   // Symbol counter width: never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned syms);
      return (clog2(syms) == 0) ? 1 : clog2(syms);
   endfunction

endpackage

// File: rtl/param_serializer_if.sv
// Parallel-in / serial-out stream bundle for param_serializer.
interface param_serializer_if #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned LANES  = 1
);
   logic [DATA_W-1:0] in_data;
   logic              in_valid;
   logic              in_ready;
   logic              msb_first;
   logic [LANES-1:0]  ser_data;
   logic              ser_valid;
   logic              ser_ready;
   logic              ser_last;

   // Serializer side: consumes words, produces symbols.
   modport slave (
      input  in_data, in_valid, msb_first, ser_ready,
      output in_ready, ser_data, ser_valid, ser_last
   );

   // Producer/sink side: drives words, accepts symbols.
   modport master (
      output in_data, in_valid, msb_first, ser_ready,
      input  in_ready, ser_data, ser_valid, ser_last
   );
endinterface

// File: rtl/param_serializer_sync_fifo.sv
// Show-ahead synchronous FIFO with occupancy count; a write while full is
// accepted only when a pop happens in the same cycle.
module sync_fifo_param
   import param_serializer_pkg::*;
#(
   parameter int unsigned DATA_W     = 8,
   parameter int unsigned FIFO_DEPTH = 128
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       i_wr_en,
   input  logic [DATA_W-1:0]          i_wr_data,
   input  logic                       i_rd_en,
   output logic [DATA_W-1:0]          o_rd_data,
   output logic [clog2(FIFO_DEPTH):0] o_count,
   output logic                       o_full,
   output logic                       o_empty
);
   localparam int unsigned AW = clog2(FIFO_DEPTH);

   logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
   logic [AW-1:0]     r_wr_ptr;
   logic [AW-1:0]     r_rd_ptr;
   logic [AW:0]       r_count;
   logic              w_wr;
   logic              w_rd;

   assign o_empty   = (r_count == '0);
   assign o_full    = (r_count == (AW+1)'(FIFO_DEPTH));
   assign o_count   = r_count;
   assign o_rd_data = r_mem[r_rd_ptr];

   assign w_rd = i_rd_en && !o_empty;
   // A pop frees the slot being written, so full+pop+write is legal.
   assign w_wr = i_wr_en && (!o_full || w_rd);

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
         unique case ({w_wr, w_rd})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage array; contents need no reset since the count gates reads.
   always_ff @(posedge clk) begin
      if (w_wr) r_mem[r_wr_ptr] <= i_wr_data;
   end

endmodule

// File: rtl/param_serializer.sv
// Buffers parallel words in a FIFO and shifts each out over LANES serial
// lanes, MSB- or LSB-first, with back-to-back word streaming.
module param_serializer
   import param_serializer_pkg::*;
#(
   parameter int unsigned DATA_W       = 8,
   parameter int unsigned LANES        = 1,
   parameter int unsigned FIFO_DEPTH   = 128,
   parameter int unsigned AFULL_THRESH = 119
) (
   input  logic                       clk,
   input  logic                       reset_n,
   param_serializer_if.slave          io_bus,
   output logic [clog2(FIFO_DEPTH):0] o_fill_count,
   output logic                       o_overflow,
   output logic                       o_busy
);
   localparam int unsigned SYMS   = calc_syms(DATA_W, LANES);
   localparam int unsigned CNT_W  = cnt_width(SYMS);
   localparam int unsigned FILL_W = clog2(FIFO_DEPTH) + 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SYMS - 1);

   state_e            r_state;
   logic [DATA_W-1:0] r_shift;
   logic              r_ord;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_ser_valid;
   logic              r_overflow;

   logic [DATA_W-1:0] w_dout;
   logic [FILL_W-1:0] w_fill;
   logic              w_full;
   logic              w_empty;
   logic              w_last;
   logic              w_pop;

   sync_fifo_param #(
      .DATA_W     (DATA_W),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset_n   (reset_n),
      .i_wr_en   (io_bus.in_valid),
      .i_wr_data (io_bus.in_data),
      .i_rd_en   (w_pop),
      .o_rd_data (w_dout),
      .o_count   (w_fill),
      .o_full    (w_full),
      .o_empty   (w_empty)
   );

   assign w_last = (r_state == StShift) && (r_cnt == LAST_CNT);
   // Pop when idle, or when the final symbol is accepted (reload without a gap).
   assign w_pop  = !w_empty && ((r_state == StIdle) || (w_last && io_bus.ser_ready));

   // The current symbol always sits at the end of the shifter facing the bit order.
   assign io_bus.ser_data  = r_ord ? r_shift[DATA_W-1 -: LANES] : r_shift[LANES-1:0];
   assign io_bus.ser_valid = r_ser_valid;
   assign io_bus.ser_last  = w_last;
   assign io_bus.in_ready  = (w_fill < FILL_W'(AFULL_THRESH));

   assign o_fill_count = w_fill;
   assign o_overflow   = r_overflow;
   assign o_busy       = (r_state == StShift) || (w_fill != '0);

   // Shifter FSM: load, shift per accepted symbol, reload or go idle after the last.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= StIdle;
         r_shift     <= '0;
         r_ord       <= 1'b0;
         r_cnt       <= '0;
         r_ser_valid <= 1'b0;
      end else begin
         unique case (r_state)
            StIdle: begin
               if (!w_empty) begin
                  r_shift     <= w_dout;
                  r_ord       <= io_bus.msb_first;
                  r_cnt       <= '0;
                  r_ser_valid <= 1'b1;
                  r_state     <= StShift;
               end
            end
            StShift: begin
               // Without ser_ready everything holds, so valid never drops unaccepted.
               if (io_bus.ser_ready) begin
                  if (r_cnt != LAST_CNT) begin
                     r_shift <= r_ord ? (r_shift << LANES) : (r_shift >> LANES);
                     r_cnt   <= r_cnt + CNT_W'(1);
                  end else if (!w_empty) begin
                     r_shift <= w_dout;
                     r_ord   <= io_bus.msb_first;
                     r_cnt   <= '0;
                  end else begin
                     r_ser_valid <= 1'b0;
                     r_state     <= StIdle;
                  end
               end
            end
            default: begin
               r_ser_valid <= 1'b0;
               r_state     <= StIdle;
            end
         endcase
      end
   end

   // Overflow pulse: a word offered while full with no pop to make room is lost.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_overflow <= 1'b0;
      end else begin
         r_overflow <= io_bus.in_valid && w_full && !w_pop;
      end
   end

endmodule

// File: tb/tb_param_serializer.sv
// Scoreboard bench for param_serializer: two DUTs (1 lane and 4 lanes, 8-bit words)
// share one stimulus stream; a monitor expands each expected word into symbols.
module tb_param_serializer;

   typedef struct {
      logic [7:0] w;
      bit         msb;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [7:0] in_data;
   logic       in_valid;
   logic       msb_first;
   logic       ser_ready;

   logic [7:0] fill_a, fill_b;
   logic       ovf_a, ovf_b, busy_a, busy_b;

   exp_t hist[$];
   int   errors = 0;
   int   checks = 0;
   int   rd_idx[2];
   int   k_sym[2];
   bit   prev_v[2];
   bit   prev_r;
   int   ovf_cnt[2];
   int   lanes_of[2] = '{1, 4};
   logic [7:0] sd[2];
   logic       sv[2];
   logic       sl[2];
   int   first_v[2], last_v[2], cnt_v[2];

   always #5 clk = ~clk;

   param_serializer_if #(.DATA_W(8), .LANES(1)) bus_a ();
   param_serializer_if #(.DATA_W(8), .LANES(4)) bus_b ();

   assign bus_a.in_data   = in_data;
   assign bus_a.in_valid  = in_valid;
   assign bus_a.msb_first = msb_first;
   assign bus_a.ser_ready = ser_ready;
   assign bus_b.in_data   = in_data;
   assign bus_b.in_valid  = in_valid;
   assign bus_b.msb_first = msb_first;
   assign bus_b.ser_ready = ser_ready;

   assign sd[0] = {7'b0, bus_a.ser_data};
   assign sd[1] = {4'b0, bus_b.ser_data};
   assign sv[0] = bus_a.ser_valid;
   assign sv[1] = bus_b.ser_valid;
   assign sl[0] = bus_a.ser_last;
   assign sl[1] = bus_b.ser_last;

   param_serializer #(.DATA_W(8), .LANES(1), .FIFO_DEPTH(128), .AFULL_THRESH(119)) u_dut_a (
      .clk          (clk),
      .reset_n      (reset_n),
      .io_bus       (bus_a),
      .o_fill_count (fill_a),
      .o_overflow   (ovf_a),
      .o_busy       (busy_a)
   );

   param_serializer #(.DATA_W(8), .LANES(4), .FIFO_DEPTH(128), .AFULL_THRESH(119)) u_dut_b (
      .clk          (clk),
      .reset_n      (reset_n),
      .io_bus       (bus_b),
      .o_fill_count (fill_b),
      .o_overflow   (ovf_b),
      .o_busy       (busy_b)
   );

   // Symbol k of a word under the given lane count and bit order.
   function automatic logic [7:0] sym_of(input exp_t e, input int lanes, input int k);
      int mask;
      mask = (1 << lanes) - 1;
      if (e.msb) return 8'((32'(e.w) >> (8 - (k + 1) * lanes)) & mask);
      else       return 8'((32'(e.w) >> (k * lanes)) & mask);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic send(input logic [7:0] w);
      in_valid = 1'b1;
      in_data  = w;
      hist.push_back('{w: w, msb: msb_first});
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_idle(input int max_cyc);
      int n;
      n = 0;
      while ((busy_a || busy_b) && n < max_cyc) begin
         @(posedge clk);
         n++;
      end
      #1;
      chk("idle_timeout", 32'(n < max_cyc), 1);
      repeat (2) @(posedge clk);
      #1;
   endtask

   // Monitor: compare every presented symbol against the expected word stream.
   always @(negedge clk) begin
      if (!reset_n) begin
         for (int d = 0; d < 2; d++) begin
            k_sym[d]  = 0;
            prev_v[d] = 1'b0;
         end
      end else begin
         for (int d = 0; d < 2; d++) begin
            if (prev_v[d] && !prev_r) chk($sformatf("hold_valid_%0d", d), 32'(sv[d]), 1);
            if (sv[d]) begin
               if (rd_idx[d] >= hist.size()) begin
                  chk($sformatf("unexpected_sym_%0d", d), 32'(sv[d]), 0);
               end else begin
                  chk($sformatf("sym_data_%0d_w%0d_k%0d", d, rd_idx[d], k_sym[d]), 32'(sd[d]),
                      32'(sym_of(hist[rd_idx[d]], lanes_of[d], k_sym[d])));
                  chk($sformatf("sym_last_%0d_w%0d_k%0d", d, rd_idx[d], k_sym[d]), 32'(sl[d]),
                      32'(k_sym[d] == 8 / lanes_of[d] - 1));
                  if (ser_ready) begin
                     k_sym[d]++;
                     if (k_sym[d] == 8 / lanes_of[d]) begin
                        k_sym[d] = 0;
                        rd_idx[d]++;
                     end
                  end
               end
            end else begin
               chk($sformatf("last_idle_%0d", d), 32'(sl[d]), 0);
            end
            prev_v[d] = sv[d];
         end
         prev_r = ser_ready;
         if (ovf_a) ovf_cnt[0]++;
         if (ovf_b) ovf_cnt[1]++;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int ef, n;
      reset_n   = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      msb_first = 1'b1;
      ser_ready = 1'b0;
      rd_idx    = '{0, 0};
      ovf_cnt   = '{0, 0};

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_valid_a", 32'(sv[0]), 0);
      chk("rst_valid_b", 32'(sv[1]), 0);
      chk("rst_data_a", 32'(sd[0]), 0);
      chk("rst_fill_a", 32'(fill_a), 0);
      chk("rst_fill_b", 32'(fill_b), 0);
      chk("rst_in_ready_a", 32'(bus_a.in_ready), 1);
      chk("rst_in_ready_b", 32'(bus_b.in_ready), 1);
      chk("rst_ovf_a", 32'(ovf_a), 0);
      chk("rst_busy_a", 32'(busy_a), 0);
      chk("rst_busy_b", 32'(busy_b), 0);
      @(posedge clk);
      #1 reset_n = 1'b1;

      // Latency: fill=1 one cycle after the write, first symbol the cycle after that
      ser_ready = 1'b1;
      msb_first = 1'b1;
      send(8'hA5);
      @(negedge clk);
      chk("lat_fill_a", 32'(fill_a), 1);
      chk("lat_fill_b", 32'(fill_b), 1);
      chk("lat_novalid_a", 32'(sv[0]), 0);
      chk("lat_novalid_b", 32'(sv[1]), 0);
      @(negedge clk);
      chk("lat_valid_a", 32'(sv[0]), 1);
      chk("lat_valid_b", 32'(sv[1]), 1);
      chk("lat_fill0_a", 32'(fill_a), 0);
      wait_idle(100);

      // Back-to-back LSB-first words must stream with no gap
      msb_first = 1'b0;
      send(8'hA5);
      send(8'h3C);
      first_v = '{-1, -1};
      last_v  = '{-1, -1};
      cnt_v   = '{0, 0};
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         for (int d = 0; d < 2; d++) begin
            if (sv[d]) begin
               cnt_v[d]++;
               if (first_v[d] < 0) first_v[d] = i;
               last_v[d] = i;
            end
         end
      end
      chk("b2b_count_a", 32'(cnt_v[0]), 16);
      chk("b2b_span_a", 32'(last_v[0] - first_v[0] + 1), 16);
      chk("b2b_count_b", 32'(cnt_v[1]), 4);
      chk("b2b_span_b", 32'(last_v[1] - first_v[1] + 1), 4);
      wait_idle(100);

      // MSB-first 0x5E: 4-lane symbols 5 then E
      msb_first = 1'b1;
      send(8'h5E);
      wait_idle(100);

      // Mid-word bit-order change is ignored; ready toggles 1,0,0,1
      send(8'hC3);
      n = 0;
      while (!sv[0] && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("wait_valid_timeout", 32'(n < 20), 1);
      msb_first = 1'b0;
      @(posedge clk);
      #1 ser_ready = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1 ser_ready = 1'b1;
      wait_idle(100);
      msb_first = 1'b1;

      // Stall the sink and overfill: 128 in the FIFO plus 1 held in the shifter
      ser_ready = 1'b0;
      for (int i = 1; i <= 130; i++) begin
         in_valid = 1'b1;
         in_data  = 8'($urandom);
         if (i <= 129) hist.push_back('{w: in_data, msb: msb_first});
         @(posedge clk);
         @(negedge clk);
         ef = (i == 1) ? 1 : ((i - 1 > 128) ? 128 : i - 1);
         chk($sformatf("stall_fill_a_%0d", i), 32'(fill_a), 32'(ef));
         chk($sformatf("stall_fill_b_%0d", i), 32'(fill_b), 32'(ef));
         chk($sformatf("stall_in_ready_a_%0d", i), 32'(bus_a.in_ready), 32'(ef < 119));
         chk($sformatf("stall_ovf_a_%0d", i), 32'(ovf_a), 32'(i == 130));
         chk($sformatf("stall_ovf_b_%0d", i), 32'(ovf_b), 32'(i == 130));
      end
      in_valid = 1'b0;
      @(negedge clk);
      chk("stall_fill_hold_a", 32'(fill_a), 128);
      chk("stall_ovf_pulse_a", 32'(ovf_a), 0);
      @(posedge clk);
      #1 ser_ready = 1'b1;
      wait_idle(3000);
      chk("stall_drained_a", 32'(rd_idx[0]), 32'(hist.size()));
      chk("stall_drained_b", 32'(rd_idx[1]), 32'(hist.size()));

      // Randomised traffic with a backpressure-obeying producer and a bursty sink
      for (int seg = 0; seg < 2; seg++) begin
         msb_first = seg[0];
         repeat (300) begin
            in_valid  = ($urandom % 2 == 0) && bus_a.in_ready && bus_b.in_ready;
            ser_ready = ($urandom % 4) != 0;
            if (in_valid) begin
               in_data = 8'($urandom);
               hist.push_back('{w: in_data, msb: msb_first});
            end
            @(posedge clk);
            #1;
         end
         in_valid  = 1'b0;
         ser_ready = 1'b1;
         wait_idle(3000);
         chk($sformatf("rand_drained_a_%0d", seg), 32'(rd_idx[0]), 32'(hist.size()));
         chk($sformatf("rand_drained_b_%0d", seg), 32'(rd_idx[1]), 32'(hist.size()));
      end
      chk("ovf_total_a", 32'(ovf_cnt[0]), 1);
      chk("ovf_total_b", 32'(ovf_cnt[1]), 1);

      // Reset mid-word with words queued: everything in flight is abandoned
      msb_first = 1'b1;
      ser_ready = 1'b1;
      for (int i = 0; i < 5; i++) send(8'($urandom));
      @(posedge clk);
      #1 reset_n = 1'b0;
      rd_idx[0] = hist.size();
      rd_idx[1] = hist.size();
      #1;
      chk("mrst_valid_a", 32'(sv[0]), 0);
      chk("mrst_valid_b", 32'(sv[1]), 0);
      chk("mrst_fill_a", 32'(fill_a), 0);
      chk("mrst_fill_b", 32'(fill_b), 0);
      chk("mrst_in_ready_a", 32'(bus_a.in_ready), 1);
      chk("mrst_busy_a", 32'(busy_a), 0);
      @(posedge clk);
      #1 reset_n = 1'b1;
      n = 0;
      repeat (20) begin
         @(negedge clk);
         if (sv[0] || sv[1]) n++;
      end
      chk("mrst_residual", 32'(n), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
